pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//   Sequences pll_module: pulses its reset at power-up and on a debounced user button press.
//   Waits for lock, qualifies it as stable, then releases the system reset.
//   Re-sequences on lock loss or lock timeout.
//   Runs on the free-running 27 MHz reference (same clock that feeds pll_module.clkin).
// PARAMETERS
//   DEBOUNCE_CYCLES      16    consecutive stable samples needed to accept a button level change
//   PLL_RST_CYCLES       8     width of the pll_reset_o pulse, in clkin_i cycles
//   LOCK_STABLE_CYCLES   64    consecutive synchronized-lock cycles required before release
//   LOCK_TIMEOUT_CYCLES  4096  cycles in WAIT_LOCK without lock before the PLL is reset again
// PORTS
//   clkin_i         in   1  27 MHz reference clock; the only clock
//   reset_i         in   1  asynchronous, active-high reset
//   button_ni       in   1  user button, active-low, bouncy, asynchronous
//   lock_i          in   1  pll_module.lock, asynchronous to clkin_i
//   pll_reset_o     out  1  drives pll_module.reset, active-high
//   sys_reset_o     out  1  active-high reset for logic on pll_module.clkout
//   ready_o         out  1  1 while in RUN
//   state_o         out  2  0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUN
//   relock_count_o  out  8  number of re-sequences since reset_i, saturating at 255
// BEHAVIOUR
//   Reset values (reset_i=1, asynchronous):
//     state=RESET_PLL, pll_reset_o=1, sys_reset_o=1, ready_o=0, relock_count_o=0.
//     All counters are cleared; debounced button = 1 (released).
//   Synchronizers:
//     lock_i and button_ni each pass through a 2-flop synchronizer (lock_s, btn_s) before any use.
//   Debouncer:
//     A counter increments while btn_s != btn_db and clears when btn_s == btn_db.
//     When the counter reaches DEBOUNCE_CYCLES, btn_db <= btn_s.
//     press = 1-cycle pulse when btn_db falls 1->0. No event on release.
//   FSM transitions (registered; all outputs registered, Moore-decoded from state):
//     RESET_PLL: pll_reset_o=1. After PLL_RST_CYCLES cycles -> WAIT_LOCK.
//     WAIT_LOCK: pll_reset_o=0, timer counts.
//       lock_s=1 -> STABILIZE.
//       Timer reaches LOCK_TIMEOUT_CYCLES -> RESET_PLL and relock++.
//     STABILIZE: stable counter counts cycles with lock_s=1.
//       lock_s=0 -> WAIT_LOCK; timer and stable counter cleared.
//       Count reaches LOCK_STABLE_CYCLES -> RUN.
//     RUN: sys_reset_o=0, ready_o=1. lock_s=0 -> RESET_PLL and relock++.
//     In any state, press -> RESET_PLL, relock++ (press has priority over all other transitions).
//     In RESET_PLL, press restarts the pulse counter.
//   Output levels:
//     sys_reset_o=1 and ready_o=0 in every state except RUN.
//     pll_reset_o=1 only in RESET_PLL.
//   Latency:
//     lock_i rise -> lock_s after 2 cycles -> STABILIZE on the next cycle.
//     sys_reset_o falls exactly LOCK_STABLE_CYCLES later, i.e. 3+LOCK_STABLE_CYCLES cycles after lock_i rises.
//     lock_i fall in RUN -> sys_reset_o=1 and pll_reset_o=1 within 3 cycles.
//   relock_count_o:
//     Increments by exactly 1 per re-entry to RESET_PLL (not on reset_i).
//     Holds at 255.
//   Counter widths: $clog2(param+1). Counters never wrap; each clears on state entry.
//   Mid-operation reset: reset_i asserted in any state immediately forces the reset values.
//     Sequencing restarts from RESET_PLL on release.
// TESTING
//   1. reset_i pulse; PLL model locks 100 cycles after pll_reset_o falls
//      -> pll_reset_o high exactly 8 cycles.
//      -> sys_reset_o falls 67 cycles after lock_i rises; ready_o=1; state_o=3; count=0.
//   2. Bouncy press (10 toggles, 20 low, 10 toggles, release), repeated 3x
//      -> exactly one press per sequence, each re-pulses pll_reset_o for 8 cycles.
//      -> relock_count_o=3; RUN is re-entered each time.
//   3. button_ni low for 12 cycles, then high
//      -> no press; state stays RUN; count unchanged.
//   4. lock_i dropped while in RUN
//      -> sys_reset_o=1 within 3 cycles; state RESET_PLL; count +1; recovers after re-lock.
//   5. lock_i held 0, with LOCK_TIMEOUT_CYCLES=32
//      -> pll_reset_o re-pulses every 8+32 cycles; count saturates at 255 after 255 timeouts.
//   6. lock_i drops 30 cycles into STABILIZE -> returns to WAIT_LOCK; sys_reset_o stays 1.
//      Then reset_i asserted mid-STABILIZE -> outputs take reset values in the same cycle.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Power-up / button / lock-loss sequencer for pll_module, clocked by the 27 MHz reference.
// Pulses the PLL reset, qualifies lock as stable, then releases the system reset.
module pll_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES     = 16,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096
) (
  input  logic       clkin_i,
  input  logic       reset_i,
  input  logic       button_ni,
  input  logic       lock_i,
  output logic       pll_reset_o,
  output logic       sys_reset_o,
  output logic       ready_o,
  output logic [1:0] state_o,
  output logic [7:0] relock_count_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic             btn_meta;
  logic             btn_s;
  logic             btn_db;
  logic             btn_db_d;
  logic             press;
  logic [DB_W-1:0]  db_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic [STB_W-1:0] stable_cnt;
  logic [TO_W-1:0]  timer;
  logic [7:0]       relock;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // Both asynchronous inputs are double-registered; the button idles released (high).
  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      btn_meta  <= 1'b1;
      btn_s     <= 1'b1;
    end else begin
      lock_meta <= lock_i;
      lock_s    <= lock_meta;
      btn_meta  <= button_ni;
      btn_s     <= btn_meta;
    end
  end

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      db_cnt   <= '0;
      btn_db   <= 1'b1;
      btn_db_d <= 1'b1;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press = btn_db_d & ~btn_db;

  // Outputs are written alongside every state change so they stay registered Moore outputs.
  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= RESET_PLL;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      timer       <= '0;
      relock      <= 8'd0;
      pll_reset_o <= 1'b1;
      sys_reset_o <= 1'b1;
      ready_o     <= 1'b0;
    end else if (press) begin
      state       <= RESET_PLL;
      rst_cnt     <= '0;
      relock      <= sat_inc(relock);
      pll_reset_o <= 1'b1;
      sys_reset_o <= 1'b1;
      ready_o     <= 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (rst_cnt == RST_LAST) begin
            state       <= WAIT_LOCK;
            timer       <= '0;
            pll_reset_o <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state      <= STABILIZE;
            stable_cnt <= '0;
          end else if (timer == TO_LAST) begin
            state       <= RESET_PLL;
            rst_cnt     <= '0;
            relock      <= sat_inc(relock);
            pll_reset_o <= 1'b1;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            timer      <= '0;
            stable_cnt <= '0;
          end else if (stable_cnt == STB_LAST) begin
            state       <= RUN;
            sys_reset_o <= 1'b0;
            ready_o     <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + STB_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state       <= RESET_PLL;
            rst_cnt     <= '0;
            relock      <= sat_inc(relock);
            pll_reset_o <= 1'b1;
            sys_reset_o <= 1'b1;
            ready_o     <= 1'b0;
          end
        end
        default: begin
          state       <= RESET_PLL;
          rst_cnt     <= '0;
          pll_reset_o <= 1'b1;
          sys_reset_o <= 1'b1;
          ready_o     <= 1'b0;
        end
      endcase
    end
  end

  assign state_o        = state;
  assign relock_count_o = relock;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: power-up, button presses, lock loss,
// lock timeout saturation (second instance with a short timeout) and mid-operation reset.
module tb_pll_reset_sequencer;

  logic       clkin_i = 1'b0;
  logic       reset_i, button_ni, lock_i;
  logic       pll_reset_o, sys_reset_o, ready_o;
  logic [1:0] state_o;
  logic [7:0] relock_count_o;

  logic       to_reset, to_button, to_lock;
  logic       to_pll_reset, to_sys_reset, to_ready;
  logic [1:0] to_state;
  logic [7:0] to_count;

  always #5 clkin_i = ~clkin_i;

  pll_reset_sequencer dut (
    .clkin_i(clkin_i), .reset_i(reset_i), .button_ni(button_ni), .lock_i(lock_i),
    .pll_reset_o(pll_reset_o), .sys_reset_o(sys_reset_o), .ready_o(ready_o),
    .state_o(state_o), .relock_count_o(relock_count_o)
  );

  pll_reset_sequencer #(.LOCK_TIMEOUT_CYCLES(32)) dut_to (
    .clkin_i(clkin_i), .reset_i(to_reset), .button_ni(to_button), .lock_i(to_lock),
    .pll_reset_o(to_pll_reset), .sys_reset_o(to_sys_reset), .ready_o(to_ready),
    .state_o(to_state), .relock_count_o(to_count)
  );

  typedef struct {
    int         cycles;
    logic       btn;
    logic       lock;
    logic       pulse;
    logic [1:0] st;
    logic       pll;
    logic       sys;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl [13];
  vec_t exp_q [$];
  int   exp_pulse_q [$];
  int   pulse_rd = 0;

  // Pulse-width monitor: records each completed pll_reset_o pulse (cycles high after reset_i release).
  int run_len = 0;
  int obs_count = 0;
  int obs_width [64];
  int cyc = 0;

  always @(negedge clkin_i) begin
    if (reset_i) begin
      run_len <= 0;
    end else if (pll_reset_o) begin
      run_len <= run_len + 1;
    end else if (run_len > 0) begin
      if (obs_count < 64) obs_width[obs_count] <= run_len;
      obs_count <= obs_count + 1;
      run_len   <= 0;
    end
  end

  always @(posedge clkin_i) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic check_pulses();
    @(posedge clkin_i);
    check("pll_reset pulse count", obs_count - pulse_rd, exp_pulse_q.size());
    while (exp_pulse_q.size() > 0) begin
      int e;
      e = exp_pulse_q.pop_front();
      if (pulse_rd < obs_count) begin
        check("pll_reset pulse width", obs_width[pulse_rd], e);
        pulse_rd++;
      end
    end
    pulse_rd = obs_count;
  endtask

  task automatic applyStimulus(input vec_t v);
    button_ni = v.btn;
    lock_i    = v.lock;
    if (v.pulse) exp_pulse_q.push_back(8);
    exp_q.push_back(v);
    repeat (v.cycles) @(negedge clkin_i);
  endtask

  task automatic checkOutput(input int step);
    vec_t e;
    logic [12:0] got, expv;
    e    = exp_q.pop_front();
    got  = {state_o, pll_reset_o, sys_reset_o, ready_o, relock_count_o};
    expv = {e.st, e.pll, e.sys, e.rdy, e.cnt};
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL step %0d: got st=%0d pll=%0d sys=%0d rdy=%0d cnt=%0d, expected st=%0d pll=%0d sys=%0d rdy=%0d cnt=%0d",
               step, state_o, pll_reset_o, sys_reset_o, ready_o, relock_count_o,
               e.st, e.pll, e.sys, e.rdy, e.cnt);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, state_o, 0);
    check({tag, " pll_reset"}, pll_reset_o, 1);
    check({tag, " sys_reset"}, sys_reset_o, 1);
    check({tag, " ready"}, ready_o, 0);
    check({tag, " relock_count"}, relock_count_o, 0);
  endtask

  // PLL model after a reset_i release: lock comes 100 cycles after pll_reset_o falls.
  task automatic lock_after_release(input int exp_count);
    int n;
    n = 0;
    while (pll_reset_o && n < 50) begin @(negedge clkin_i); n++; end
    check("pll_reset released", pll_reset_o, 0);
    repeat (100) @(negedge clkin_i);
    lock_i = 1'b1;
    n = 0;
    do begin @(negedge clkin_i); n++; end while (sys_reset_o && n < 300);
    check("lock rise to sys_reset fall cycles", n, 67);
    check("ready in RUN", ready_o, 1);
    check("state RUN", state_o, 3);
    check("relock_count after lock", relock_count_o, exp_count);
  endtask

  task automatic bouncy_press();
    for (int i = 0; i < 10; i++) begin button_ni = i[0]; @(negedge clkin_i); end
    button_ni = 1'b0;
    repeat (20) @(negedge clkin_i);
    for (int i = 0; i < 10; i++) begin button_ni = i[0]; @(negedge clkin_i); end
    button_ni = 1'b1;
    repeat (30) @(negedge clkin_i);
  endtask

  task automatic pll_follow();
    int n;
    n = 0;
    while (!pll_reset_o && n < 100) begin @(negedge clkin_i); n++; end
    check("press pulses pll_reset", pll_reset_o, 1);
    lock_i = 1'b0;
    n = 0;
    while (pll_reset_o && n < 50) begin @(negedge clkin_i); n++; end
    repeat (100) @(negedge clkin_i);
    lock_i = 1'b1;
  endtask

  initial begin
    int n;
    int last_rise;

    tbl[0]  = '{12, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[1]  = '{20, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[2]  = '{3,  1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[3]  = '{8,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd4};
    tbl[4]  = '{3,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd4};
    tbl[5]  = '{63, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd4};
    tbl[6]  = '{1,  1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd4};
    tbl[7]  = '{11, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[8]  = '{33, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[9]  = '{3,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[10] = '{40, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[11] = '{3,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[12] = '{20, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd5};

    reset_i = 1'b1; button_ni = 1'b1; lock_i = 1'b0;
    to_reset = 1'b1; to_button = 1'b1; to_lock = 1'b0;

    $display("[TB] power-up sequence");
    repeat (3) @(negedge clkin_i);
    check_reset_values("reset");
    exp_pulse_q.push_back(8);
    @(posedge clkin_i);
    #1 reset_i = 1'b0;
    lock_after_release(0);
    check_pulses();

    $display("[TB] bouncy button presses");
    for (int rep = 1; rep <= 3; rep++) begin
      exp_pulse_q.push_back(8);
      fork
        bouncy_press();
        pll_follow();
      join
      n = 0;
      while (!ready_o && n < 400) begin @(negedge clkin_i); n++; end
      check("RUN re-entered after press", state_o, 3);
      check("relock_count after press", relock_count_o, rep);
    end
    check_pulses();

    $display("[TB] short press, lock loss, STABILIZE abort");
    @(negedge clkin_i);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(i);
    end
    check_pulses();

    $display("[TB] reset mid-STABILIZE");
    reset_i = 1'b1;
    #1;
    check_reset_values("mid reset");
    lock_i = 1'b0;
    exp_pulse_q.push_back(8);
    @(posedge clkin_i);
    #1 reset_i = 1'b0;
    lock_after_release(0);
    check_pulses();

    $display("[TB] lock timeout with short timeout instance");
    @(posedge clkin_i);
    #1 to_reset = 1'b0;
    last_rise = 0;
    for (int k = 1; k <= 260; k++) begin
      n = 0;
      while (to_pll_reset && n < 100) begin @(negedge clkin_i); n++; end
      n = 0;
      while (!to_pll_reset && n < 100) begin @(negedge clkin_i); n++; end
      if (k >= 2) check("timeout re-pulse period", cyc - last_rise, 40);
      last_rise = cyc;
      check("timeout relock_count", to_count, (k > 255) ? 255 : k);
      check("timeout state", to_state, 0);
      check("timeout sys_reset/ready", {to_sys_reset, to_ready}, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
